// File: rtl/key_debounce_if.sv
// Signal bundle between the raw contact inputs and the debounced key outputs.
// The master drives the raw levels; the debouncer (slave) drives everything else.
interface key_debounce_if #(
  parameter int N_KEYS = 5
);
  logic [N_KEYS-1:0] keys_raw;
  logic [N_KEYS-1:0] keys_level;
  logic [N_KEYS-1:0] keys_press;
  logic [N_KEYS-1:0] keys_release;
  logic              any_press;

  modport master (
    output keys_raw,
    input  keys_level, keys_press, keys_release, any_press
  );

  modport slave (
    input  keys_raw,
    output keys_level, keys_press, keys_release, any_press
  );
endinterface

// File: rtl/key_debounce.sv
// Per-channel synchroniser + debounce FSM for the vending machine buttons and coin
// switches; produces a clean level plus single-cycle press/release pulses.
module key_debounce #(
  parameter int N_KEYS          = 5,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clk,
  input  logic            reset,
  key_debounce_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARM_HI,
    HELD,
    ARM_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  state_t            state [N_KEYS];
  logic [CNT_W-1:0]  cnt   [N_KEYS];
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours (s2 must see the old s1, not the new one).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.keys_raw;
      s2 <= s1;
    end
  end

  // NOTE: the per-channel state/counter arrays are plain flops, not RAM, so they
  // are cleared by the asynchronous reset like any other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        case (state[i])
          IDLE: begin
            if (s2[i]) begin
              state[i] <= ARM_HI;
              cnt[i]   <= '0;
            end
          end
          ARM_HI: begin
            if (!s2[i]) begin
              state[i] <= IDLE;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]   <= HELD;
              level_q[i] <= 1'b1;
              press_q[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          HELD: begin
            if (!s2[i]) begin
              state[i] <= ARM_LO;
              cnt[i]   <= '0;
            end
          end
          ARM_LO: begin
            if (s2[i]) begin
              state[i] <= HELD;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]     <= IDLE;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  // Output stage: keeps every output a flop and puts level and pulse in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.keys_level   <= '0;
      bus.keys_press   <= '0;
      bus.keys_release <= '0;
      bus.any_press    <= 1'b0;
    end else begin
      bus.keys_level   <= level_q;
      bus.keys_press   <= press_q;
      bus.keys_release <= release_q;
      bus.any_press    <= |press_q;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed + randomized bench for key_debounce; outputs are compared each cycle
// against a run-length acceptance model of the debounce rules.
module tb_key_debounce;
  localparam int N = 5;
  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  key_debounce_if #(.N_KEYS(N)) bus ();

  key_debounce #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Reference model: a change is accepted once the synchronised input has
  // disagreed with the accepted level for D+1 consecutive samples.
  logic [N-1:0] m_s1, m_s2, acc, ev_press, ev_rel;
  logic [N-1:0] o_level, o_press, o_rel;
  logic         o_any;
  int           run [N];

  // Observed-event tallies for the directed scenarios.
  int n_press [N];
  int n_rel   [N];
  int n_level [N];

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; acc = '0; ev_press = '0; ev_rel = '0;
    o_level = '0; o_press = '0; o_rel = '0; o_any = 1'b0;
    for (int i = 0; i < N; i++) run[i] = 0;
  endtask

  task automatic model_step();
    o_level = acc;
    o_press = ev_press;
    o_rel   = ev_rel;
    o_any   = |ev_press;
    ev_press = '0;
    ev_rel   = '0;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != acc[i]) begin
        run[i]++;
        if (run[i] == D + 1) begin
          acc[i] = m_s2[i];
          run[i] = 0;
          if (acc[i]) ev_press[i] = 1'b1;
          else        ev_rel[i]   = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = bus.keys_raw;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_level[i] = 0;
    end
  endtask

  // One clock: advance the model at the edge, then compare just after it.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_clear();
    #1;
    check("level",   bus.keys_level,   o_level);
    check("press",   bus.keys_press,   o_press);
    check("release", bus.keys_release, o_rel);
    check("any",     bus.any_press,    o_any);
    for (int i = 0; i < N; i++) begin
      if (bus.keys_press[i] === 1'b1)   n_press[i]++;
      if (bus.keys_release[i] === 1'b1) n_rel[i]++;
      if (bus.keys_level[i] === 1'b1)   n_level[i]++;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int hold [N];

    bus.keys_raw = '0;
    model_clear();
    clear_counts();

    // Reset held with every key pressed, then released: all keys fire together.
    #1;
    rst_n = 1'b0;
    bus.keys_raw = 5'b11111;
    #1;
    check("rst_outputs_zero", {bus.keys_level, bus.keys_press, bus.keys_release, bus.any_press}, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_held_zero", {bus.keys_level, bus.keys_press, bus.keys_release, bus.any_press}, '0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_press_edge7", bus.keys_press, (i == 7) ? 5'b11111 : 5'b00000);
      check("rst_level", bus.keys_level, (i >= 7) ? 5'b11111 : 5'b00000);
    end
    bus.keys_raw = '0;
    ticks(12);

    // Clean press and release on bit 2.
    clear_counts();
    bus.keys_raw = 5'b00100;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("clean_press2", bus.keys_press[2], i == 7);
      check("clean_any", bus.any_press, i == 7);
    end
    bus.keys_raw = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("clean_release2", bus.keys_release[2], i == 7);
    end
    check("clean_press_count", n_press[2], 1);
    check("clean_release_count", n_rel[2], 1);
    check("clean_level_cycles", n_level[2], 20);

    // Glitch rejection on bit 0: 4 cycles rejected, 5 cycles accepted.
    clear_counts();
    bus.keys_raw = 5'b00001;
    ticks(4);
    bus.keys_raw = '0;
    ticks(12);
    check("glitch4_press0", n_press[0], 0);
    check("glitch4_level0", n_level[0], 0);
    clear_counts();
    bus.keys_raw = 5'b00001;
    ticks(5);
    bus.keys_raw = '0;
    ticks(14);
    check("glitch5_press0", n_press[0], 1);
    check("glitch5_release0", n_rel[0], 1);

    // Release bounce on bit 3 while held.
    bus.keys_raw = 5'b01000;
    ticks(12);
    check("bounce_held3", bus.keys_level[3], 1'b1);
    clear_counts();
    bus.keys_raw = 5'b00000;
    ticks(3);
    bus.keys_raw = 5'b01000;
    ticks(12);
    check("bounce_no_release3", n_rel[3], 0);
    check("bounce_no_repress3", n_press[3], 0);
    check("bounce_level3", n_level[3], 15);
    bus.keys_raw = '0;
    ticks(12);

    // Simultaneous channels: bits 0 and 4 together, bit 1 two cycles later.
    for (int i = 0; i < 14; i++) begin
      if (i == 0) bus.keys_raw = 5'b10001;
      if (i == 2) bus.keys_raw = 5'b10011;
      tick();
      check("simul_press", bus.keys_press,
            (i == 7) ? 5'b10001 : (i == 9) ? 5'b00010 : 5'b00000);
      check("simul_any", bus.any_press, (i == 7) || (i == 9));
    end
    bus.keys_raw = '0;
    ticks(12);

    // Mid-count reset on bit 1 (ARM_HI with cnt=2 after five edges).
    bus.keys_raw = 5'b00010;
    ticks(5);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("midrst_zero", {bus.keys_level, bus.keys_press, bus.keys_release, bus.any_press}, '0);
    ticks(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst_press1", bus.keys_press, (i == 7) ? 5'b00010 : 5'b00000);
    end
    bus.keys_raw = '0;
    ticks(12);

    // Randomized phase: each key toggles after a random hold of 1..10 cycles,
    // straddling the acceptance threshold.
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 10);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          bus.keys_raw[i] = ~bus.keys_raw[i];
          hold[i] = $urandom_range(1, 10);
        end
      end
      tick();
    end
    bus.keys_raw = '0;
    ticks(12);
    check("final_level_clear", bus.keys_level, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioner for the vending machine's board push-buttons and coin switches. Each raw, asynchronous contact input is synchronised, debounced, and turned into a clean level plus single-cycle press and release pulses. It sits directly upstream of `VendingMachine`, whose `coin1`, `coin2`, `buy`, `confirm_flag` and `cancel_flag` inputs are driven from this block's outputs.

## Interface
Parameters:
- `N_KEYS`, default 5: number of independent channels. Bit map: 0=coin1, 1=coin2, 2=buy, 3=confirm, 4=cancel.
- `DEBOUNCE_CYCLES`, default 2_000_000: cycles an input must stay stable before it is accepted. This is 20 ms at 100 MHz. Legal range is 2 or more; benches use 4.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each channel's counter.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `keys_raw` input N_KEYS: raw contact levels, asynchronous to `clk`, 1 = pressed.
- `keys_level` output N_KEYS: debounced level per channel.
- `keys_press` output N_KEYS: 1-cycle pulse when a channel is accepted as pressed.
- `keys_release` output N_KEYS: 1-cycle pulse when a channel is accepted as released.
- `any_press` output 1: OR of `keys_press`, registered in the same cycle as the pulse.

## Operation
- Every channel is fully independent. Each has its own 2-flop synchroniser (`s1`, `s2`), a `CNT_W`-bit counter `cnt`, and a 4-state FSM.
- FSM states and transitions, evaluated on each rising `clk` using `s2`:
  - IDLE (stable low): if `s2`=1, go to ARM_HI with `cnt`=0.
  - ARM_HI:
    - if `s2`=0, go to IDLE. The glitch is rejected and no pulse is produced.
    - else if `cnt`=DEBOUNCE_CYCLES-1, go to HELD, set `keys_level`=1 and `keys_press`=1 for one cycle.
    - else increment `cnt`.
  - HELD (stable high): if `s2`=0, go to ARM_LO with `cnt`=0.
  - ARM_LO:
    - if `s2`=1, go to HELD. The bounce is ignored and `keys_level` stays 1.
    - else if `cnt`=DEBOUNCE_CYCLES-1, go to IDLE, set `keys_level`=0 and `keys_release`=1 for one cycle.
    - else increment `cnt`.
- `keys_level` changes only on the IDLE→HELD and ARM_LO→IDLE transitions. It is constant during the ARM states.
- `cnt` never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Simultaneous events:
  - Any number of channels may pulse in the same cycle. The downstream block resolves priority.
  - `keys_press` and `keys_release` are never both 1 on one channel.
  - Each of the two pulses has a minimum spacing of DEBOUNCE_CYCLES+1 cycles on a channel.
- Reset (asynchronous assert, any time including mid-count):
  - `s1`, `s2`, `cnt` and all outputs go to 0, and every FSM goes to IDLE.
  - A key still held when reset deasserts is treated as a new press. `keys_press` fires DEBOUNCE_CYCLES+3 edges after the first clock edge following deassertion.

## Timing
- All outputs are registered, with no combinational path from `keys_raw`.
- Reset values: `keys_level`=0, `keys_press`=0, `keys_release`=0, `any_press`=0.
- Press latency: if `keys_raw` rises before edge 0 and stays stable, `keys_press` is high during the cycle after edge DEBOUNCE_CYCLES+3. It sits in the same cycle that `keys_level` first reads 1.
- Release latency is identical: DEBOUNCE_CYCLES+3 edges to the `keys_release` pulse.
- Acceptance threshold: a high (or low) excursion is accepted only if it holds for at least DEBOUNCE_CYCLES+1 consecutive samples at `s2`. Shorter excursions produce no pulse and no level change.
- Pulse width is exactly 1 cycle, regardless of how long the key is held.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and N_KEYS=5.
- **Reset:** hold `reset`=0 for 3 cycles with `keys_raw`=5'b11111 → all outputs 0 throughout. Release `reset` → `keys_press`=5'b11111 exactly one cycle at edge 7, and `keys_level`=5'b11111 thereafter.
- **Clean press/release:** raise bit 2 for 20 cycles, then drop → `keys_press[2]` single pulse after edge 7, `keys_level[2]` high for 20 cycles, `keys_release[2]` single pulse 7 edges after the fall, `any_press` matches `keys_press[2]`.
- **Glitch rejection:** pulse bit 0 high for 4 cycles (one below threshold) → no `keys_press` and `keys_level[0]` stays 0. Repeat with 5 cycles → exactly one `keys_press[0]`.
- **Release bounce:** with bit 3 in HELD, drop it for 3 cycles then restore → no `keys_release[3]`, `keys_level[3]` stays 1, and no second `keys_press[3]`.
- **Simultaneous channels:** raise bits 0 and 4 on the same cycle, and bit 1 two cycles later → `keys_press` reads 5'b10001 in one cycle and 5'b00010 two cycles later. `any_press` is high in both cycles.
- **Mid-count reset:** assert `reset` while bit 1 is in ARM_HI with `cnt`=2 → `cnt` and the FSM clear immediately. After deassertion with the key still held, the press fires at edge 7 after release.
